// File: rtl/hdc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hdc_pkg
// Brief   : Shared types and constants for the hyperdimensional class bundler
// Rev     : 1.0  initial release
// ============================================================================
package hdc_pkg;

  // Default hypervector width and counter/count widths
  localparam int HV_D   = 10000;
  localparam int CW_DEF = 8;
  localparam int NW_DEF = 16;

  // Bundler control states
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FINAL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Symmetric saturation magnitude for a signed counter of width cw.
  // The most negative code is deliberately never used so +/- limits match.
  function automatic int sat_lim(input int cw);
    return (1 << (cw - 1)) - 1;
  endfunction

endpackage : hdc_pkg
`default_nettype wire

// File: rtl/hv_bit_counter.sv
`default_nettype none
// ============================================================================
// Module  : hv_bit_counter
// Brief   : Signed saturating up/down counter for one hypervector bit position
// Rev     : 1.0  initial release
// ============================================================================
module hv_bit_counter
  import hdc_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic pos,
  output logic zero
);

  localparam int                   LIM  = sat_lim(CW);
  localparam logic signed [CW-1:0] MAXV = CW'(LIM);
  localparam logic signed [CW-1:0] MINV = -MAXV;
  localparam logic signed [CW-1:0] ONE  = CW'(1);

  logic signed [CW-1:0] cnt;

  // Vote counter: clear wins, then step toward the requested direction unless at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAXV)) begin
      cnt <= cnt + ONE;
    end else if (dec && (cnt != MINV)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);
  assign pos  = !cnt[CW-1] && !zero;

endmodule : hv_bit_counter
`default_nettype wire

// File: rtl/hv_class_bundler.sv
`default_nettype none
// ============================================================================
// Module  : hv_class_bundler
// Brief   : Accumulates training hypervectors into per-bit vote counters and
//           emits the bitwise-majority class hypervector on request
// Rev     : 1.0  initial release
// ============================================================================
module hv_class_bundler
  import hdc_pkg::*;
#(
  parameter int   D       = HV_D,
  parameter int   CW      = CW_DEF,
  parameter int   NW      = NW_DEF,
  parameter logic TIE_VAL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  in_vec,
  input  logic          finalize,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  class_vec,
  output logic [NW-1:0] n_count
);

  state_t       state;
  state_t       state_nxt;
  logic         accept;
  logic [D-1:0] pos_v;
  logic [D-1:0] zero_v;
  logic [D-1:0] class_nxt;

  // clear suppresses any accept in the same cycle
  assign accept = in_valid && in_ready && !clear;

  generate
    for (genvar i = 0; i < D; i++) begin : g_bit
      hv_bit_counter #(
        .CW (CW)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear),
        .inc  (accept && in_vec[i]),
        .dec  (accept && !in_vec[i]),
        .pos  (pos_v[i]),
        .zero (zero_v[i])
      );
    end
  endgenerate

  // Majority decision per bit, zero-count bits take the tie value
  always_comb begin
    class_nxt = '0;
    for (int i = 0; i < D; i++) begin
      class_nxt[i] = pos_v[i] ? 1'b1 : (zero_v[i] ? TIE_VAL : 1'b0);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; clear forces a return to accumulation
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (finalize) begin
          state_nxt = FINAL;
        end
      end
      FINAL: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
    if (clear) begin
      state_nxt = ACCUM;
    end
  end

  // Capture the class vector once counters include the finalizing vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_vec <= '0;
    end else if ((state == FINAL) && !clear) begin
      class_vec <= class_nxt;
    end
  end

  // Saturating count of accepted training vectors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_count <= '0;
    end else if (clear) begin
      n_count <= '0;
    end else if (accept && (n_count != {NW{1'b1}})) begin
      n_count <= n_count + NW'(1);
    end
  end

endmodule : hv_class_bundler
`default_nettype wire
